// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared types and encodings for the multi-cycle RV32I control unit.
//   state_e    FSM states (value is visible on state_o)
//   alu_op_e   ALU operation codes driven on alu_op
//   imm_type_e immediate format select for the immediate generator
//   OPC_*      RV32I major opcodes
//   PC_SRC_*, WB_*, A_* datapath mux encodings
package rv_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEM       = 3'd3,
      S_WRITEBACK = 3'd4,
      S_TRAP      = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_XOR  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_AND  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_type_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JALR   = 2'd2;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;

   localparam logic [1:0] A_RS1  = 2'd0;
   localparam logic [1:0] A_PC   = 2'd1;
   localparam logic [1:0] A_ZERO = 2'd2;

endpackage

// File: rtl/rv_alu_decoder.sv
// rv_alu_decoder: combinational opcode/funct3/funct7 -> ALU operation + legality.
//   opcode  in  7  instr[6:0]
//   funct3  in  3  instr[14:12]
//   funct7  in  7  instr[31:25]
//   alu_op  out 4  rv_ctrl_pkg::alu_op_e
//   legal   out 1  instruction is supported by this core
module rv_alu_decoder
   import rv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alu_op,
   output logic       legal
);

   always_comb begin
      alu_op = ALU_ADD;
      legal  = 1'b1;
      case (opcode)
         OPC_OP, OPC_OP_IMM: begin
            case (funct3)
               // SUB only exists in R-type; ADDI with imm[10]=1 is still an add
               3'b000:  alu_op = (opcode == OPC_OP && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_op = ALU_SLL;
               3'b010:  alu_op = ALU_SLT;
               3'b011:  alu_op = ALU_SLTU;
               3'b100:  alu_op = ALU_XOR;
               3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
               3'b110:  alu_op = ALU_OR;
               default: alu_op = ALU_AND;
            endcase
            // funct7 is a real field for R-type and for shift-immediates; elsewhere it is imm bits
            if (opcode == OPC_OP || funct3 == 3'b001 || funct3 == 3'b101) begin
               if (funct7 == 7'b0100000)
                  legal = (funct3 == 3'b000 && opcode == OPC_OP) || funct3 == 3'b101;
               else
                  legal = (funct7 == 7'b0000000);
            end
         end
         OPC_LOAD:  legal = !(funct3 inside {3'b011, 3'b110, 3'b111});
         OPC_STORE: legal = (funct3[2] == 1'b0) && (funct3 != 3'b011);
         OPC_BRANCH: begin
            case (funct3[2:1])
               2'b00:   alu_op = ALU_SUB;   // BEQ/BNE
               2'b10:   alu_op = ALU_SLT;   // BLT/BGE
               2'b11:   alu_op = ALU_SLTU;  // BLTU/BGEU
               default: legal  = 1'b0;
            endcase
         end
         OPC_JALR: legal = (funct3 == 3'b000);
         OPC_JAL, OPC_LUI, OPC_AUIPC: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: FSM control unit for the multi-cycle RV32I core.
// Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over one shared memory port.
//   clk, resetn (sync, active-low)
//   instr, mem_ready, branch_taken                    inputs
//   mem_req/mem_we/mem_addr_sel                       memory port control
//   ir_write, pc_write, pc_src                        IR / PC update
//   alu_a_sel, alu_b_sel, alu_op, imm_type,
//   limit_immediate                                   ALU / immediate control
//   reg_write, wb_sel                                 regfile writeback
//   illegal_instr, halted, state_o                    status / debug
// Optional: define CTRL_PERF_CNT_EN to add cycle_cnt / instret_cnt outputs.
module rv_multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int ALU_OP_W     = 4,
   parameter bit ILLEGAL_TRAP = 1'b1,
   parameter int CNT_W        = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [31:0]         instr,
   input  logic                mem_ready,
   input  logic                branch_taken,
   output logic                mem_req,
   output logic                mem_we,
   output logic                mem_addr_sel,
   output logic                ir_write,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic [1:0]          alu_a_sel,
   output logic                alu_b_sel,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [2:0]          imm_type,
   output logic                limit_immediate,
   output logic                reg_write,
   output logic [1:0]          wb_sel,
   output logic                illegal_instr,
   output logic                halted,
   output logic [2:0]          state_o
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [CNT_W-1:0]    instret_cnt
`endif
);

   state_e     state_q, state_d;
   logic       halted_q, halted_d;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [3:0] dec_alu_op;
   logic       dec_legal;
   logic       is_load, is_store;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign is_load  = (opcode == OPC_LOAD);
   assign is_store = (opcode == OPC_STORE);

   rv_alu_decoder u_alu_dec (
      .opcode (opcode),
      .funct3 (funct3),
      .funct7 (instr[31:25]),
      .alu_op (dec_alu_op),
      .legal  (dec_legal)
   );

   // Shift-immediates only use shamt; held in every state so the immgen never sees imm[11:5]
   assign limit_immediate = (opcode == OPC_OP_IMM) && (funct3 == 3'b001 || funct3 == 3'b101);

   // Datapath selects follow the instruction class; they stay put across EXECUTE/MEM/WRITEBACK
   always_comb begin
      alu_a_sel = A_RS1;
      alu_b_sel = 1'b1;
      imm_type  = IMM_I;
      alu_op    = ALU_OP_W'(dec_alu_op);
      case (opcode)
         OPC_OP:     alu_b_sel = 1'b0;
         OPC_STORE:  imm_type  = IMM_S;
         OPC_BRANCH: begin alu_b_sel = 1'b0; imm_type = IMM_B; end
         OPC_JAL:    imm_type  = IMM_J;
         OPC_LUI:    begin alu_a_sel = A_ZERO; imm_type = IMM_U; end
         OPC_AUIPC:  begin alu_a_sel = A_PC;   imm_type = IMM_U; end
         default: ;
      endcase
      if (!resetn) begin
         alu_a_sel = '0;
         alu_b_sel = 1'b0;
         imm_type  = '0;
         alu_op    = '0;
      end
   end

   // Next state and strobes. Strobes are combinational so mem_req can drop in the reset cycle
   // and ir_write/pc_write can fire in the same cycle mem_ready completes the fetch.
   always_comb begin
      state_d       = state_q;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr_sel  = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = PC_SRC_PLUS4;
      reg_write     = 1'b0;
      wb_sel        = WB_ALU;
      illegal_instr = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!dec_legal) begin
               illegal_instr = 1'b1;
               state_d       = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            case (opcode)
               OPC_LOAD, OPC_STORE: state_d = S_MEM;
               OPC_BRANCH: begin
                  pc_write = branch_taken;
                  pc_src   = PC_SRC_BRANCH;
                  state_d  = S_FETCH;
               end
               OPC_JAL, OPC_JALR: begin
                  pc_write  = 1'b1;
                  pc_src    = (opcode == OPC_JAL) ? PC_SRC_BRANCH : PC_SRC_JALR;
                  reg_write = 1'b1;
                  wb_sel    = WB_PC4;
                  state_d   = S_FETCH;
               end
               default: state_d = S_WRITEBACK;
            endcase
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = is_store;
            if (mem_ready) state_d = is_store ? S_FETCH : S_WRITEBACK;
         end
         S_WRITEBACK: begin
            reg_write = 1'b1;
            wb_sel    = is_load ? WB_LOAD : WB_ALU;
            state_d   = S_FETCH;
         end
         default: state_d = S_TRAP;  // TRAP absorbs; unused encodings fall in too
      endcase
      if (!resetn) begin
         mem_req       = 1'b0;
         mem_we        = 1'b0;
         mem_addr_sel  = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         pc_src        = '0;
         reg_write     = 1'b0;
         wb_sel        = '0;
         illegal_instr = 1'b0;
      end
      halted_d = (state_d == S_TRAP);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_FETCH;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   assign halted  = halted_q;
   assign state_o = state_q;

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
   logic             unused_bits;

   // Any return to FETCH from another state retires an instruction; reset entry never gets here
   always_comb begin
      cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
      instret_cnt_d = instret_cnt_q;
      if (state_d == S_FETCH && state_q != S_FETCH) instret_cnt_d = instret_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         cycle_cnt_q   <= cycle_cnt_d;
         instret_cnt_q <= instret_cnt_d;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
   assign unused_bits = ^{instr[24:15], instr[11:7]};
`else
   logic unused_bits;
   // Register specifiers belong to the datapath; CNT_W only matters with counters enabled
   assign unused_bits = ^{instr[24:15], instr[11:7], CNT_W[0]};
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
module tb_rv_multicycle_ctrl;

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_SRAI = 32'h4030D093;
   localparam logic [31:0] I_LW   = 32'h0080A283;
   localparam logic [31:0] I_SW   = 32'h0020A423;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_JAL  = 32'h000000EF;
   localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

   logic        clk = 1'b0;
   logic        resetn, mem_ready, branch_taken;
   logic [31:0] instr;
   logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
   logic [1:0]  pc_src, alu_a_sel, wb_sel;
   logic        alu_b_sel, limit_immediate, reg_write, illegal_instr, halted;
   logic [3:0]  alu_op;
   logic [2:0]  imm_type, state_o;
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rv_multicycle_ctrl dut (
      .clk             (clk),
      .resetn          (resetn),
      .instr           (instr),
      .mem_ready       (mem_ready),
      .branch_taken    (branch_taken),
      .mem_req         (mem_req),
      .mem_we          (mem_we),
      .mem_addr_sel    (mem_addr_sel),
      .ir_write        (ir_write),
      .pc_write        (pc_write),
      .pc_src          (pc_src),
      .alu_a_sel       (alu_a_sel),
      .alu_b_sel       (alu_b_sel),
      .alu_op          (alu_op),
      .imm_type        (imm_type),
      .limit_immediate (limit_immediate),
      .reg_write       (reg_write),
      .wb_sel          (wb_sel),
      .illegal_instr   (illegal_instr),
      .halted          (halted),
      .state_o         (state_o)
`ifdef CTRL_PERF_CNT_EN
      ,
      .cycle_cnt       (cycle_cnt),
      .instret_cnt     (instret_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Inputs change 1ns after the edge, checks happen 2ns after it
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int bad;
      resetn = 1'b0; instr = '0; mem_ready = 1'b0; branch_taken = 1'b0;
      @(posedge clk); #2;
      chk("rst_req",    32'(mem_req), 0);
      chk("rst_state",  32'(state_o), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_alu_op", 32'(alu_op), 0);

      // add: FETCH, DECODE, EXECUTE, WRITEBACK, then FETCH in cycle 5
      resetn = 1'b1; instr = I_ADD; mem_ready = 1'b1; #1;
      chk("add_f_req",  32'(mem_req), 1);
      chk("add_f_irw",  32'(ir_write), 1);
      chk("add_f_pcw",  32'(pc_write), 1);
      nxt(); #1;
      chk("add_d_state", 32'(state_o), 1);
      nxt(); #1;
      chk("add_x_op",   32'(alu_op), 0);
      chk("add_x_bsel", 32'(alu_b_sel), 0);
      chk("add_x_rw",   32'(reg_write), 0);
      nxt(); #1;
      chk("add_wb_rw",  32'(reg_write), 1);
      chk("add_wb_sel", 32'(wb_sel), 0);
      nxt(); instr = I_SUB; #1;
      chk("add_done",   32'(state_o), 0);

      // sub
      nxt(); nxt(); #1;
      chk("sub_x_op",   32'(alu_op), 1);
      nxt(); nxt(); instr = I_SRAI; #1;
      chk("srai_f_lim", 32'(limit_immediate), 1);

      // srai
      nxt(); nxt(); #1;
      chk("srai_x_op",  32'(alu_op), 7);
      chk("srai_x_bsel", 32'(alu_b_sel), 1);
      chk("srai_x_lim", 32'(limit_immediate), 1);
      nxt(); nxt(); instr = I_LW; #1;

      // lw with two wait cycles in MEM; mem_ready high in EXECUTE is ignored
      nxt(); nxt(); #1;
      chk("lw_x_req",   32'(mem_req), 0);
      nxt(); mem_ready = 1'b0; #1;
      chk("lw_m_state", 32'(state_o), 3);
      chk("lw_m_req0",  32'(mem_req), 1);
      chk("lw_m_asel",  32'(mem_addr_sel), 1);
      chk("lw_m_we",    32'(mem_we), 0);
      nxt(); #1;
      chk("lw_m_req1",  32'(mem_req), 1);
      nxt(); mem_ready = 1'b1; #1;
      chk("lw_m_req2",  32'(mem_req), 1);
      chk("lw_m_rw",    32'(reg_write), 0);
      nxt(); #1;
      chk("lw_wb_state", 32'(state_o), 4);
      chk("lw_wb_rw",   32'(reg_write), 1);
      chk("lw_wb_sel",  32'(wb_sel), 1);
      nxt(); instr = I_BEQ; #1;
      chk("lw_done",    32'(state_o), 0);

      // beq taken, then not taken
      nxt(); nxt(); branch_taken = 1'b1; #1;
      chk("beq_t_pcw",  32'(pc_write), 1);
      chk("beq_t_src",  32'(pc_src), 1);
      chk("beq_t_rw",   32'(reg_write), 0);
      chk("beq_t_op",   32'(alu_op), 1);
      nxt(); #1;
      chk("beq_t_done", 32'(state_o), 0);
      nxt(); nxt(); branch_taken = 1'b0; #1;
      chk("beq_n_pcw",  32'(pc_write), 0);
      nxt(); instr = I_SW; #1;

      // sw: 4 cycles, write enable in MEM
      nxt(); nxt(); nxt(); #1;
      chk("sw_m_state", 32'(state_o), 3);
      chk("sw_m_we",    32'(mem_we), 1);
      nxt(); instr = I_JAL; #1;
      chk("sw_done",    32'(state_o), 0);

      // jal
      nxt(); nxt(); #1;
      chk("jal_x_rw",   32'(reg_write), 1);
      chk("jal_x_wb",   32'(wb_sel), 2);
      chk("jal_x_src",  32'(pc_src), 1);
      nxt(); instr = I_ILL; #1;
      chk("jal_done",   32'(state_o), 0);

      // illegal -> TRAP, held with mem_ready still high
      nxt(); #1;
      chk("ill_pulse",  32'(illegal_instr), 1);
      nxt(); #1;
      chk("trap_state", 32'(state_o), 5);
      chk("trap_halt",  32'(halted), 1);
      chk("trap_ill0",  32'(illegal_instr), 0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         nxt(); #1;
         if (mem_req !== 1'b0 || halted !== 1'b1 || state_o !== 3'd5) bad++;
      end
      chk("trap_hold_bad", 32'(bad), 0);
      nxt(); resetn = 1'b0; #1;
      chk("trap_rst_req", 32'(mem_req), 0);
      nxt(); resetn = 1'b1; instr = I_LW; #1;
      chk("trap_rst_state", 32'(state_o), 0);
      chk("trap_rst_halt",  32'(halted), 0);
      chk("trap_rst_req1",  32'(mem_req), 1);

      // reset during a MEM wait
      nxt(); nxt(); nxt(); mem_ready = 1'b0; #1;
      chk("mrst_req_pre", 32'(mem_req), 1);
      nxt(); resetn = 1'b0; #1;
      chk("mrst_req",  32'(mem_req), 0);
      chk("mrst_rw",   32'(reg_write), 0);
      chk("mrst_pcw",  32'(pc_write), 0);
      nxt(); resetn = 1'b1; #1;
      chk("mrst_state", 32'(state_o), 0);
`ifdef CTRL_PERF_CNT_EN
      chk("mrst_cyc",  cycle_cnt, 0);
      chk("mrst_ret",  instret_cnt, 0);
      nxt(); #1;
      chk("mrst_cyc1", cycle_cnt, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
